// File: rtl/l2arb_pkg.sv
// Shared types and constants for the L1-to-L2 arbiter slice.
package l2arb_pkg;

  localparam int L2_BLOCK_W = 256;
  localparam int L2_OFF_W   = $clog2(L2_BLOCK_W / 8);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } l2arb_state_t;

  // Encoded so the single grant bit from the picker maps straight onto the owner.
  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } l2arb_owner_t;

endpackage

// File: rtl/l2arb_pick.sv
// Combinational winner selection between icache and dcache requests.
// Round-robin tie-breaking is built only when L2ARB_RR_EN is defined.
module l2arb_pick
  import l2arb_pkg::*;
(
  input  logic ic_req,
  input  logic dc_req,
  input  logic ptr,
  output logic grant,
  output logic grant_valid
);

  // grant = 1 selects dcache; ptr = 1 means dcache is favoured on a tie.
  always_comb begin
    grant_valid = ic_req | dc_req;
`ifdef L2ARB_RR_EN
    if (ic_req && dc_req) begin
      grant = ptr;
    end else begin
      grant = dc_req;
    end
`else
    grant = dc_req;
`endif
  end

`ifndef L2ARB_RR_EN
  logic unused_ptr;
  assign unused_ptr = ptr;
`endif

endmodule

// File: rtl/l2_arbiter.sv
// Single-outstanding L2 port shared by icache refills and dcache refills/writebacks.
// Define L2ARB_RR_EN for round-robin tie-breaking; otherwise dcache always wins ties.
module l2_arbiter
  import l2arb_pkg::*;
#(
  parameter int BLOCK_W = L2_BLOCK_W,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ic_req,
  input  logic [ADDR_W-1:0]  ic_addr,
  input  logic               ic_flush,
  output logic               ic_done,
  input  logic               dc_req,
  input  logic               dc_we,
  input  logic [ADDR_W-1:0]  dc_addr,
  input  logic [BLOCK_W-1:0] dc_wdata,
  output logic               dc_done,
  output logic [BLOCK_W-1:0] rsp_block,
  output logic               l2_req_valid,
  output logic               l2_req_we,
  output logic [ADDR_W-1:0]  l2_req_addr,
  output logic [BLOCK_W-1:0] l2_req_wdata,
  input  logic               l2_req_ready,
  input  logic               l2_resp_valid,
  input  logic [ADDR_W-1:0]  l2_resp_addr,
  input  logic [BLOCK_W-1:0] l2_resp_block
);

  localparam int OFF_W = $clog2(BLOCK_W / 8);

  l2arb_state_t      state;
  l2arb_owner_t      owner;
  logic              drop;
  logic              rr_ptr;
  logic              ic_live;
  logic              grant;
  logic              grant_valid;
  l2arb_owner_t      grant_owner;
  logic              grant_we;
  logic [ADDR_W-1:0] grant_addr;
  logic              flush_hit;
  logic              ic_done_ok;
  logic              resp_hit;

  // A mispredict in the same cycle as the icache request means the refill is already stale.
  assign ic_live = ic_req & ~ic_flush;

  l2arb_pick u_pick (
    .ic_req      (ic_live),
    .dc_req      (dc_req),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign grant_owner = l2arb_owner_t'(grant);
  assign grant_we    = (grant_owner == OWN_DC) && dc_we;
  assign grant_addr  = (grant_owner == OWN_DC) ? {dc_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}}
                                               : {ic_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  assign flush_hit  = (owner == OWN_IC) && ic_flush;
  assign ic_done_ok = (owner == OWN_IC) && !drop && !ic_flush;
  assign resp_hit   = l2_resp_valid &&
                      (l2_resp_addr[ADDR_W-1:OFF_W] == l2_req_addr[ADDR_W-1:OFF_W]);

`ifdef L2ARB_RR_EN
  // After every grant the other requester becomes favoured, dropped refills included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b1;
    end else if (state == IDLE && grant_valid) begin
      rr_ptr <= (grant_owner == OWN_IC);
    end
  end
`else
  assign rr_ptr = 1'b1;
`endif

  // The l2_req_* registers double as the latched transaction, so requester inputs
  // are free to change once the grant has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= OWN_DC;
      drop         <= 1'b0;
      ic_done      <= 1'b0;
      dc_done      <= 1'b0;
      rsp_block    <= '0;
      l2_req_valid <= 1'b0;
      l2_req_we    <= 1'b0;
      l2_req_addr  <= '0;
      l2_req_wdata <= '0;
    end else begin
      ic_done <= 1'b0;
      dc_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner        <= grant_owner;
            drop         <= 1'b0;
            l2_req_valid <= 1'b1;
            l2_req_we    <= grant_we;
            l2_req_addr  <= grant_addr;
            l2_req_wdata <= grant_we ? dc_wdata : '0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (flush_hit) begin
            drop <= 1'b1;
          end
          if (l2_req_ready) begin
            l2_req_valid <= 1'b0;
            if (l2_req_we) begin
              dc_done <= (owner == OWN_DC);
              ic_done <= ic_done_ok;
              state   <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (flush_hit) begin
            drop <= 1'b1;
          end
          // Responses for other blocks belong to someone else and are skipped.
          if (resp_hit) begin
            rsp_block <= l2_resp_block;
            dc_done   <= (owner == OWN_DC);
            ic_done   <= ic_done_ok;
            state     <= RESP;
          end
        end
        RESP: begin
          drop  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  logic unused_lsbs;
  assign unused_lsbs = ^{ic_addr[OFF_W-1:0], dc_addr[OFF_W-1:0], l2_resp_addr[OFF_W-1:0]};

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_l2_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_req, ic_flush, ic_done;
  logic [31:0]  ic_addr;
  logic         dc_req, dc_we, dc_done;
  logic [31:0]  dc_addr;
  logic [255:0] dc_wdata, rsp_block;
  logic         l2_req_valid, l2_req_we, l2_req_ready;
  logic [31:0]  l2_req_addr;
  logic [255:0] l2_req_wdata;
  logic         l2_resp_valid;
  logic [31:0]  l2_resp_addr;
  logic [255:0] l2_resp_block;

  int n_checks = 0;
  int n_pass   = 0;

  l2_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ic_req        (ic_req),
    .ic_addr       (ic_addr),
    .ic_flush      (ic_flush),
    .ic_done       (ic_done),
    .dc_req        (dc_req),
    .dc_we         (dc_we),
    .dc_addr       (dc_addr),
    .dc_wdata      (dc_wdata),
    .dc_done       (dc_done),
    .rsp_block     (rsp_block),
    .l2_req_valid  (l2_req_valid),
    .l2_req_we     (l2_req_we),
    .l2_req_addr   (l2_req_addr),
    .l2_req_wdata  (l2_req_wdata),
    .l2_req_ready  (l2_req_ready),
    .l2_resp_valid (l2_resp_valid),
    .l2_resp_addr  (l2_resp_addr),
    .l2_resp_block (l2_resp_block)
  );

  always #5 clk = ~clk;

  // Transaction-level model: at most one transaction, tracked by its lifecycle stage.
  bit           m_busy, m_issuing, m_waiting, m_finishing;
  bit           m_owner_dc, m_we, m_drop, m_fav_dc;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;
  bit           exp_ic_done, exp_dc_done;
  logic [255:0] exp_rsp;

  bit ic_active, dc_active;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [31:0] block_of(logic [31:0] a);
    return a - (a % 32);
  endfunction

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic modelReset();
    m_busy = 0; m_issuing = 0; m_waiting = 0; m_finishing = 0;
    m_owner_dc = 0; m_we = 0; m_drop = 0; m_fav_dc = 1;
    m_addr = '0; m_wdata = '0;
    exp_ic_done = 0; exp_dc_done = 0; exp_rsp = '0;
  endtask

  task automatic idleInputs();
    ic_req = 0; ic_flush = 0; ic_addr = '0;
    dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
    l2_req_ready = 0; l2_resp_valid = 0; l2_resp_addr = '0; l2_resp_block = '0;
    ic_active = 0; dc_active = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic modelUpdate();
    bit ic_ok, pick_dc, nxt_ic, nxt_dc;
    nxt_ic = 0;
    nxt_dc = 0;
    if (!m_busy) begin
      ic_ok = ic_req && !ic_flush;
      if (ic_ok || dc_req) begin
`ifdef L2ARB_RR_EN
        pick_dc = dc_req && (!ic_ok || m_fav_dc);
        m_fav_dc = !pick_dc;
`else
        pick_dc = dc_req;
`endif
        m_busy = 1; m_issuing = 1; m_drop = 0;
        m_owner_dc = pick_dc;
        m_we    = pick_dc && dc_we;
        m_addr  = block_of(pick_dc ? dc_addr : ic_addr);
        m_wdata = dc_wdata;
      end
    end else if (m_finishing) begin
      m_busy = 0; m_finishing = 0; m_drop = 0;
    end else begin
      if (!m_owner_dc && ic_flush) m_drop = 1;
      if (m_issuing) begin
        if (l2_req_ready) begin
          m_issuing = 0;
          if (m_we) begin
            m_finishing = 1;
            nxt_dc = 1;
          end else begin
            m_waiting = 1;
          end
        end
      end else if (m_waiting && l2_resp_valid && (l2_resp_addr / 32 == m_addr / 32)) begin
        m_waiting = 0; m_finishing = 1;
        exp_rsp = l2_resp_block;
        if (m_owner_dc) nxt_dc = 1;
        else if (!m_drop) nxt_ic = 1;
      end
    end
    exp_ic_done = nxt_ic;
    exp_dc_done = nxt_dc;
  endtask

  task automatic checkOutput();
    check("ic_done", ic_done, exp_ic_done);
    check("dc_done", dc_done, exp_dc_done);
    check("rsp_block", rsp_block, exp_rsp);
    check("l2_req_valid", l2_req_valid, m_issuing);
    if (m_issuing) begin
      check("l2_req_addr", l2_req_addr, m_addr);
      check("l2_req_we", l2_req_we, m_we);
      if (m_we) check("l2_req_wdata", l2_req_wdata, m_wdata);
    end
  endtask

  task automatic step();
    checkOutput();
    modelUpdate();
    @(negedge clk);
  endtask

  // Random requesters that hold requests until done, plus a random L2 responder.
  task automatic applyStimulus();
    if (ic_active) begin
      if (exp_ic_done) begin
        ic_active = 0; ic_req = 0; ic_flush = 0;
      end else if ($urandom % 40 == 0) begin
        ic_active = 0; ic_req = 0; ic_flush = 1;
      end else begin
        ic_flush = 0;
      end
    end else begin
      ic_flush = ($urandom % 20 == 0);
      if ($urandom % 3 == 0) begin
        ic_active = 1; ic_req = 1; ic_addr = $urandom;
      end
    end
    if (dc_active) begin
      if (exp_dc_done) begin
        dc_active = 0; dc_req = 0;
      end
    end else if ($urandom % 3 == 0) begin
      dc_active = 1; dc_req = 1;
      dc_we = $urandom % 2; dc_addr = $urandom; dc_wdata = rand256();
    end
    if (m_busy) begin
      ic_addr = $urandom; dc_addr = $urandom; dc_we = $urandom % 2; dc_wdata = rand256();
    end
    l2_req_ready  = ($urandom % 3 == 0);
    l2_resp_block = rand256();
    l2_resp_valid = 0;
    if (m_waiting) begin
      case ($urandom % 10)
        0, 1, 2: begin
          l2_resp_valid = 1;
          l2_resp_addr  = m_addr | ($urandom % 32);
        end
        3, 4: begin
          l2_resp_valid = 1;
          l2_resp_addr  = m_addr ^ (32'h40 << $urandom_range(0, 25));
        end
        default: l2_resp_valid = 0;
      endcase
    end else if ($urandom % 8 == 0) begin
      l2_resp_valid = 1;
      l2_resp_addr  = $urandom;
    end
  endtask

  task automatic doReset();
    rst_n = 0;
    idleInputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    modelReset();
  endtask

  initial begin : main
    logic [255:0] blk;
    int           order [4];
    int           n_done;
    logic [31:0]  wr_addr;
    logic [255:0] wr_data;

    rst_n = 1;
    idleInputs();
    modelReset();
    #1 rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    check("reset ic_done", ic_done, 0);
    check("reset dc_done", dc_done, 0);
    check("reset rsp_block", rsp_block, 0);
    check("reset l2_req_valid", l2_req_valid, 0);
    check("reset l2_req_addr", l2_req_addr, 0);
    check("reset l2_req_wdata", l2_req_wdata, 0);
    rst_n = 1;

    // icache read, immediate accept, response five cycles later
    ic_req = 1; ic_addr = 32'h0000_1044;
    step();
    l2_req_ready = 1;
    check("t1 valid", l2_req_valid, 1);
    check("t1 addr", l2_req_addr, 32'h0000_1040);
    step();
    l2_req_ready = 0;
    for (int i = 0; i < 4; i++) step();
    l2_resp_valid = 1; l2_resp_addr = 32'h0000_1040; l2_resp_block = {32{8'hA5}};
    step();
    l2_resp_valid = 0; ic_req = 0;
    check("t1 ic_done", ic_done, 1);
    check("t1 dc_done", dc_done, 0);
    check("t1 rsp_block", rsp_block, {32{8'hA5}});
    step();
    check("t1 ic_done width", ic_done, 0);
    step();

    // Both requesters held high: grant order
    doReset();
    ic_req = 1; dc_req = 1; ic_addr = 32'h3000; dc_addr = 32'h3000; dc_we = 0;
    l2_req_ready = 1; l2_resp_valid = 1; l2_resp_addr = 32'h3000; l2_resp_block = rand256();
    n_done = 0;
    for (int i = 0; i < 4; i++) order[i] = 2;
    for (int cyc = 0; cyc < 40 && n_done < 4; cyc++) begin
      if (ic_done) begin order[n_done] = 0; n_done++; end
      else if (dc_done) begin order[n_done] = 1; n_done++; end
      if (n_done == 4) begin
        ic_req = 0; dc_req = 0; l2_req_ready = 0; l2_resp_valid = 0;
      end
      step();
    end
    check("t2 done count", n_done, 4);
`ifdef L2ARB_RR_EN
    check("t2 grant0", order[0], 1);
    check("t2 grant1", order[1], 0);
    check("t2 grant2", order[2], 1);
    check("t2 grant3", order[3], 0);
`else
    check("t2 grant0", order[0], 1);
    check("t2 grant1", order[1], 1);
    check("t2 grant2", order[2], 1);
    check("t2 grant3", order[3], 1);
`endif
    idleInputs();
    for (int i = 0; i < 3; i++) step();

    // dcache write with delayed ready; fields must stay put while requester inputs churn
    wr_addr = 32'h200;
    wr_data = {8{32'h1234_5678}};
    dc_req = 1; dc_we = 1; dc_addr = wr_addr; dc_wdata = wr_data;
    step();
    for (int i = 0; i < 4; i++) begin
      dc_addr = $urandom; dc_wdata = rand256();
      l2_req_ready = (i == 3);
      check("t3 valid", l2_req_valid, 1);
      check("t3 addr", l2_req_addr, wr_addr);
      check("t3 we", l2_req_we, 1);
      check("t3 wdata", l2_req_wdata, wr_data);
      step();
    end
    l2_req_ready = 0;
    check("t3 dc_done", dc_done, 1);
    check("t3 valid dropped", l2_req_valid, 0);
    dc_req = 0;
    step();
    check("t3 dc_done width", dc_done, 0);
    step();

    // Flush during WAIT suppresses ic_done; dcache is served afterwards
    blk = rand256();
    ic_req = 1; ic_addr = 32'h1040;
    step();
    l2_req_ready = 1;
    step();
    l2_req_ready = 0; ic_flush = 1; ic_req = 0;
    step();
    ic_flush = 0;
    step();
    l2_resp_valid = 1; l2_resp_addr = 32'h1040; l2_resp_block = blk;
    step();
    l2_resp_valid = 0;
    check("t4 no ic_done", ic_done, 0);
    dc_req = 1; dc_we = 0; dc_addr = 32'h500;
    step();
    check("t4 idle valid", l2_req_valid, 0);
    step();
    check("t4 dc valid", l2_req_valid, 1);
    check("t4 dc addr", l2_req_addr, 32'h500);
    l2_req_ready = 1;
    step();
    l2_req_ready = 0; l2_resp_valid = 1; l2_resp_addr = 32'h500; l2_resp_block = blk;
    step();
    l2_resp_valid = 0; dc_req = 0;
    check("t4 dc_done", dc_done, 1);
    step();
    step();

    // Response for another block is ignored
    ic_req = 1; ic_addr = 32'h1040;
    step();
    l2_req_ready = 1;
    step();
    l2_req_ready = 0; l2_resp_valid = 1; l2_resp_addr = 32'h2040; l2_resp_block = {8{32'hDEAD_BEEF}};
    step();
    check("t5 ignore mismatch", ic_done, 0);
    l2_resp_addr = 32'h1040; l2_resp_block = {8{32'hCAFE_F00D}};
    step();
    l2_resp_valid = 0; ic_req = 0;
    check("t5 ic_done", ic_done, 1);
    check("t5 rsp_block", rsp_block, {8{32'hCAFE_F00D}});
    step();
    step();

    // Asynchronous reset while waiting for L2
    ic_req = 1; ic_addr = 32'h1040;
    step();
    l2_req_ready = 1;
    step();
    l2_req_ready = 0;
    checkOutput();
    #2 rst_n = 0;
    #1;
    check("t6 valid", l2_req_valid, 0);
    check("t6 addr", l2_req_addr, 0);
    check("t6 rsp_block", rsp_block, 0);
    check("t6 ic_done", ic_done, 0);
    @(negedge clk);
    rst_n = 1;
    modelReset();
    idleInputs();
    blk = rand256();
    ic_req = 1; ic_addr = 32'h7044;
    step();
    check("t6 fresh valid", l2_req_valid, 1);
    check("t6 fresh addr", l2_req_addr, 32'h7040);
    l2_req_ready = 1;
    step();
    l2_req_ready = 0; l2_resp_valid = 1; l2_resp_addr = 32'h7040; l2_resp_block = blk;
    step();
    l2_resp_valid = 0; ic_req = 0;
    check("t6 fresh ic_done", ic_done, 1);
    check("t6 fresh rsp_block", rsp_block, blk);
    step();
    step();

    // Randomized traffic against the model
    idleInputs();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      applyStimulus();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
